arb_request_buffer: RTL and testbench

- Requester-side companion to the two-input req/ack arbiter used at each ring router output port.
- Buffers flits from one source (input channel or local processor) in a small FIFO and raises req while a flit is waiting and the output link can accept it.
- On a same-cycle ack it pops the head flit and launches it onto the shared link one cycle later.
- Also tracks grant wait time and flags req/ack protocol violations.

---
 rtl/arb_request_buffer.sv | 103 ++++++++++
 tb/tb_arb_request_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_request_buffer.sv
// arb_request_buffer: requester-side FIFO for a two-input req/ack arbiter.
// Raises req while a flit is buffered and the link is ready, and launches the granted flit one cycle after ack.
`default_nettype none

module arb_request_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              link_ready,
  output logic              req,
  input  logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              starved,
  output logic              ack_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ack_err_q, ack_err_d;
  logic              push, pop;

  // Ready and request depend only on registered occupancy, so a push is never visible the same cycle.
  assign in_ready = (count_q != FULL_CNT);
  assign req      = (count_q != '0) && link_ready;
  assign push     = in_valid && in_ready;
  assign pop      = req && ack;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = pop;
    out_data_d  = out_data_q;
    ack_err_d   = ack_err_q | (ack & ~req);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (!req || pop)        wait_cnt_d = '0;
    else if (!(&wait_cnt_q)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_err_q   <= ack_err_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wait_cnt  = wait_cnt_q;
  assign starved   = &wait_cnt_q;
  assign ack_err   = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_request_buffer.sv
// tb_arb_request_buffer: directed self-checking bench for arb_request_buffer.
`default_nettype none

module tb_arb_request_buffer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int WAIT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              link_ready;
  logic              req;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;
  logic              ack_err;

  logic ack_follow;
  logic ack_man;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  assign ack = ack_follow ? req : ack_man;

  arb_request_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .link_ready(link_ready), .req(req), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .wait_cnt(wait_cnt),
    .starved(starved), .ack_err(ack_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; link_ready = 1'b1;
    ack_follow = 1'b0; ack_man = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready cyc %0d got %b exp 1", i, in_ready); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req cyc %0d got %b exp 0", i, req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d got %b exp 0", i, out_valid); end
      checks++; if (wait_cnt !== 8'd0 || starved !== 1'b0) begin errors++; $display("FAIL reset_wait cyc %0d got %0d/%b exp 0/0", i, wait_cnt, starved); end
      checks++; if (ack_err !== 1'b0 || out_data !== 64'd0) begin errors++; $display("FAIL reset_err_data cyc %0d got %b/%h exp 0/0", i, ack_err, out_data); end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    ack_follow = 1'b1;
    in_valid = 1'b1; in_data = 64'hA5;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", req); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_c1 req/ov got %b/%b exp 1/0", req, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hA5) begin errors++; $display("FAIL single_c2 ov/data got %b/%h exp 1/a5", out_valid, out_data); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_c2_req got %b exp 0", req); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 64'hA5) begin errors++; $display("FAIL single_c3 ov/data got %b/%h exp 0/a5", out_valid, out_data); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 64'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready push %0d got %b exp 1", k, in_ready); end
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", in_ready); end
    in_data = 64'd5;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_5th rdy/ov got %b/%b exp 0/0", in_ready, out_valid); end
    // full with a pop in the same cycle still refuses the push
    ack_man = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 64'(k)) begin errors++; $display("FAIL drain flit %0d ov/data got %b/%h exp 1/%h", k, out_valid, out_data, k); end
    end
    ack_man = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_empty req/rdy got %b/%b exp 0/1", req, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_after ov got %b exp 0", out_valid); end
  endtask

  task automatic test_wait_saturate();
    do_reset();
    in_valid = 1'b1; in_data = 64'h77;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || wait_cnt !== 8'd0) begin errors++; $display("FAIL wait_start req/cnt got %b/%0d exp 1/0", req, wait_cnt); end
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 10 || i == 254 || i == 255 || i == 300) begin
        checks++; if (wait_cnt !== 8'((i > 255) ? 255 : i)) begin errors++; $display("FAIL wait_cnt at %0d got %0d exp %0d", i, wait_cnt, (i > 255) ? 255 : i); end
        checks++; if (starved !== (i >= 255)) begin errors++; $display("FAIL starved at %0d got %b exp %b", i, starved, i >= 255); end
      end
    end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    #1;
    checks++; if (wait_cnt !== 8'd0 || starved !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'h77) begin
      errors++; $display("FAIL wait_ack cnt/starved/ov/data got %0d/%b/%b/%h exp 0/0/1/77", wait_cnt, starved, out_valid, out_data);
    end
  endtask

  task automatic test_link_stall();
    do_reset();
    in_valid = 1'b1; in_data = 64'hB1;
    tick();
    in_data = 64'hB2;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (wait_cnt !== 8'd3) begin errors++; $display("FAIL stall_pre_wait got %0d exp 3", wait_cnt); end
    link_ready = 1'b0; ack_follow = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_req_drop got %b exp 0", req); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (req !== 1'b0 || out_valid !== 1'b0 || wait_cnt !== 8'd0) begin
        errors++; $display("FAIL stall cyc %0d req/ov/cnt got %b/%b/%0d exp 0/0/0", i, req, out_valid, wait_cnt);
      end
    end
    link_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hB1) begin errors++; $display("FAIL stall_out1 ov/data got %b/%h exp 1/b1", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hB2 || req !== 1'b0) begin errors++; $display("FAIL stall_out2 ov/data/req got %b/%h/%b exp 1/b2/0", out_valid, out_data, req); end
  endtask

  task automatic test_ack_err();
    do_reset();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || req !== 1'b0) begin
        errors++; $display("FAIL ack_err cyc %0d err/ov/rdy/req got %b/%b/%b/%b exp 1/0/1/0", i, ack_err, out_valid, in_ready, req);
      end
      tick();
    end
    do_reset();
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL ack_err_reset got %b exp 0", ack_err); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    link_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 64'(8'hC0 + k);
      tick();
    end
    in_valid = 1'b0;
    link_ready = 1'b1; ack_man = 1'b1; reset = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL midop_grant req got %b exp 1", req); end
    tick();
    ack_man = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || req !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_reset ov/req/rdy got %b/%b/%b exp 0/0/1", out_valid, req, in_ready);
    end
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || req !== 1'b0 || out_data !== 64'd0) begin
      errors++; $display("FAIL midop_after ov/req/data got %b/%b/%h exp 0/0/0", out_valid, req, out_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_follow = 1'b1;
    in_valid = 1'b1; in_data = 64'hD0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      in_data = 64'(8'hD0 + k);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 64'(8'hD0 + k - 1)) begin
        errors++; $display("FAIL b2b flit %0d ov/data got %b/%h exp 1/%h", k, out_valid, out_data, 8'hD0 + k - 1);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hD5 || req !== 1'b0) begin
      errors++; $display("FAIL b2b_last ov/data/req got %b/%h/%b exp 1/d5/0", out_valid, out_data, req);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_wait_saturate();
    test_link_stall();
    test_ack_err();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
